// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one of N cached-bus masters at a time onto the single
// downstream cbus port and holds the grant until the burst's last beat.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   m_valid/m_is_write [N]      per-master request valid / write flag
//   m_size [3*N], m_addr [32*N], m_strobe [4*N], m_data [32*N], m_len [4*N]
//                               per-master request fields, master k at slice k
//   m_ready/m_last [N]          per-master beat accepted / last beat
//   m_rdata [32]                shared read data, valid for the granted master
//   s_valid ... s_len           downstream request (fields of granted master)
//   s_ready, s_last, s_rdata    downstream beat handshake and read data
//   busy, grant [N]             grant held / one-hot grant (0 when idle)
//
// Build option: CBUS_ARBITER_ROUND_ROBIN_EN rotates priority starting at the
// index after the previous winner; otherwise the lowest requesting index wins.
// Request/response paths are combinational through the granted master.
module cbus_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    m_valid,
  input  logic [N-1:0]    m_is_write,
  input  logic [3*N-1:0]  m_size,
  input  logic [32*N-1:0] m_addr,
  input  logic [4*N-1:0]  m_strobe,
  input  logic [32*N-1:0] m_data,
  input  logic [4*N-1:0]  m_len,
  output logic [N-1:0]    m_ready,
  output logic [N-1:0]    m_last,
  output logic [31:0]     m_rdata,
  output logic            s_valid,
  output logic            s_is_write,
  output logic [2:0]      s_size,
  output logic [31:0]     s_addr,
  output logic [3:0]      s_strobe,
  output logic [31:0]     s_data,
  output logic [3:0]      s_len,
  input  logic            s_ready,
  input  logic            s_last,
  input  logic [31:0]     s_rdata,
  output logic            busy,
  output logic [N-1:0]    grant
);

  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_base;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] win_off;
  logic [IDX_W-1:0] win_idx;
  logic [SUM_W-1:0] win_sum;
  logic             found;

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] win_next;
  logic [SUM_W-1:0] inc_sum;
  assign rr_base = rr_q;
`else
  assign rr_base = '0;
`endif

  // Winner search: rotate requests so the search start sits at bit 0, take
  // the lowest set bit, then map the offset back to a master index mod N.
  always_comb begin
    req_rot = N'({m_valid, m_valid} >> rr_base);
    found   = 1'b0;
    win_off = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        win_off = IDX_W'(k);
      end
    end
    win_sum = {1'b0, rr_base} + {1'b0, win_off};
    if (win_sum >= SUM_W'(N)) begin
      win_sum = win_sum - SUM_W'(N);
    end
    win_idx = IDX_W'(win_sum);
  end

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
  // Next search start: one past the winner, wrapping at N.
  always_comb begin
    inc_sum = {1'b0, win_idx} + SUM_W'(1);
    if (inc_sum >= SUM_W'(N)) begin
      inc_sum = '0;
    end
    win_next = IDX_W'(inc_sum);
  end
`endif

  // Next-state: grant on any request in IDLE, release on the last beat.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          state_d = BUSY;
          sel_d   = win_idx;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
          rr_d    = win_next;
`endif
        end
      end
      BUSY: begin
        if (s_ready && s_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux: everything is zero unless a grant is held.
  always_comb begin
    m_ready    = '0;
    m_last     = '0;
    m_rdata    = '0;
    s_valid    = 1'b0;
    s_is_write = 1'b0;
    s_size     = '0;
    s_addr     = '0;
    s_strobe   = '0;
    s_data     = '0;
    s_len      = '0;
    busy       = 1'b0;
    grant      = '0;
    if (state_q == BUSY) begin
      busy    = 1'b1;
      m_rdata = s_rdata;
      for (int k = 0; k < int'(N); k++) begin
        if (sel_q == IDX_W'(k)) begin
          s_valid    = m_valid[k];
          s_is_write = m_is_write[k];
          s_size     = m_size[3*k +: 3];
          s_addr     = m_addr[32*k +: 32];
          s_strobe   = m_strobe[4*k +: 4];
          s_data     = m_data[32*k +: 32];
          s_len      = m_len[4*k +: 4];
          m_ready[k] = s_ready;
          m_last[k]  = s_last;
          grant[k]   = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed scenarios with literal expectations, then
// randomized masters and downstream responder, all checked every cycle
// against a transaction-level reference model of the arbiter.
module tb_cbus_arbiter;

  localparam int unsigned N = 2;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    m_valid, m_is_write;
  logic [3*N-1:0]  m_size;
  logic [32*N-1:0] m_addr, m_data;
  logic [4*N-1:0]  m_strobe, m_len;
  logic [N-1:0]    m_ready, m_last;
  logic [31:0]     m_rdata;
  logic            s_valid, s_is_write;
  logic [2:0]      s_size;
  logic [31:0]     s_addr, s_data;
  logic [3:0]      s_strobe, s_len;
  logic            s_ready, s_last;
  logic [31:0]     s_rdata;
  logic            busy;
  logic [N-1:0]    grant;

  cbus_arbiter #(.N(N), .IDX_W(1)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_is_write(m_is_write), .m_size(m_size),
    .m_addr(m_addr), .m_strobe(m_strobe), .m_data(m_data), .m_len(m_len),
    .m_ready(m_ready), .m_last(m_last), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_is_write(s_is_write), .s_size(s_size),
    .s_addr(s_addr), .s_strobe(s_strobe), .s_data(s_data), .s_len(s_len),
    .s_ready(s_ready), .s_last(s_last), .s_rdata(s_rdata),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbiter seen as "who owns the bus" plus priority start.
  bit           mdl_on = 1'b0;
  bit           mdl_busy = 1'b0;
  int           mdl_owner = 0;
  int           mdl_rr = 0;
  int           beat_cnt = 0;
  logic [N-1:0] done_q = '0;

  function automatic int pick(input logic [N-1:0] v, input int start);
    int w = -1;
    for (int j = 0; j < int'(N); j++) begin
      int c = (start + j) % int'(N);
      if (w < 0 && v[c]) w = c;
    end
    return w;
  endfunction

  function automatic int start_idx();
    return RR ? mdl_rr : 0;
  endfunction

  always @(posedge clk) begin
    done_q <= '0;
    if (reset) begin
      mdl_on   <= 1'b1;
      mdl_busy <= 1'b0;
      mdl_owner <= 0;
      mdl_rr   <= 0;
      beat_cnt <= 0;
    end else if (!mdl_busy) begin
      if (m_valid != '0) begin
        mdl_busy  <= 1'b1;
        mdl_owner <= pick(m_valid, start_idx());
        mdl_rr    <= (pick(m_valid, start_idx()) + 1) % int'(N);
      end
    end else if (s_ready) begin
      if (s_last) begin
        mdl_busy <= 1'b0;
        beat_cnt <= 0;
        done_q   <= N'(1) << mdl_owner;
      end else begin
        beat_cnt <= beat_cnt + 1;
      end
    end
  end

  task automatic check_cycle();
    logic [N-1:0] eg, er, el;
    logic         ev, ew;
    logic [2:0]   esz;
    logic [31:0]  ea, ed;
    logic [3:0]   es, el4;
    int           k;
    eg = '0; er = '0; el = '0; ev = 1'b0; ew = 1'b0;
    esz = '0; ea = '0; ed = '0; es = '0; el4 = '0;
    if (mdl_busy) begin
      k   = mdl_owner;
      ev  = m_valid[k];
      ew  = m_is_write[k];
      esz = m_size[3*k +: 3];
      ea  = m_addr[32*k +: 32];
      ed  = m_data[32*k +: 32];
      es  = m_strobe[4*k +: 4];
      el4 = m_len[4*k +: 4];
      eg  = N'(1) << k;
      er  = s_ready ? eg : '0;
      el  = s_last ? eg : '0;
      chk("m_rdata", 64'(m_rdata), 64'(s_rdata));
    end
    chk("busy", 64'(busy), 64'(mdl_busy));
    chk("grant", 64'(grant), 64'(eg));
    chk("s_valid", 64'(s_valid), 64'(ev));
    chk("s_is_write", 64'(s_is_write), 64'(ew));
    chk("s_size", 64'(s_size), 64'(esz));
    chk("s_addr", 64'(s_addr), 64'(ea));
    chk("s_data", 64'(s_data), 64'(ed));
    chk("s_strobe", 64'(s_strobe), 64'(es));
    chk("s_len", 64'(s_len), 64'(el4));
    chk("m_ready", 64'(m_ready), 64'(er));
    chk("m_last", 64'(m_last), 64'(el));
  endtask

  initial forever begin
    @(negedge clk);
    if (mdl_on) check_cycle();
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [31:0] addr,
                         input logic [3:0] len, input logic [31:0] data,
                         input logic [3:0] strb);
    m_valid[k]          = 1'b1;
    m_is_write[k]       = wr;
    m_size[3*k +: 3]    = 3'($urandom_range(0, 2));
    m_addr[32*k +: 32]  = addr;
    m_len[4*k +: 4]     = len;
    m_data[32*k +: 32]  = data;
    m_strobe[4*k +: 4]  = strb;
  endtask

  task automatic clr_req(input int k);
    m_valid[k] = 1'b0;
  endtask

  // Runs n beats for the granted master k, starting in a BUSY cycle.
  task automatic beats(input int k, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      s_ready = 1'b1;
      s_last  = (b == n - 1);
      s_rdata = base + 32'(b);
      @(negedge clk);
      chk("beat_grant", 64'(grant), 64'(N'(1) << k));
      chk("beat_ready", 64'(m_ready), 64'(N'(1) << k));
      chk("beat_last", 64'(m_last), (b == n - 1) ? 64'(N'(1) << k) : 64'(0));
      cyc();
    end
    s_ready = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    int first, other;
    reset = 1'b1;
    m_valid = '0; m_is_write = '0; m_size = '0; m_addr = '0;
    m_data = '0; m_strobe = '0; m_len = '0;
    s_ready = 1'b0; s_last = 1'b0; s_rdata = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_s_valid", 64'(s_valid), 64'(0));
    cyc();
    reset = 1'b0;

    // Single read.
    set_req(0, 1'b0, 32'h1FC0_0000, 4'd0, 32'h0, 4'h0);
    @(negedge clk);
    chk("arb_latency_s_valid", 64'(s_valid), 64'(0));
    cyc();
    s_ready = 1'b1; s_last = 1'b1; s_rdata = 32'h3C08_BFC0;
    @(negedge clk);
    chk("single_s_valid", 64'(s_valid), 64'(1));
    chk("single_s_addr", 64'(s_addr), 64'h1FC0_0000);
    chk("single_m_ready", 64'(m_ready), 64'b01);
    chk("single_m_last", 64'(m_last), 64'b01);
    chk("single_m_rdata", 64'(m_rdata), 64'h3C08_BFC0);
    cyc();
    clr_req(0); s_ready = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("single_idle_after", 64'(busy), 64'(0));

    // Four-beat burst from master 1.
    cyc();
    set_req(1, 1'b0, 32'h8000_0000, 4'd3, 32'h0, 4'h0);
    cyc();
    beats(1, 4, 32'h1000_0000);
    clr_req(1);
    @(negedge clk);
    chk("burst_idle_after", 64'(busy), 64'(0));

    // Contention: master 0 first, master 1 after one idle cycle.
    cyc();
    set_req(0, 1'b0, 32'h0000_0040, 4'd0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0000_0080, 4'd0, 32'h0, 4'h0);
    cyc();
    beats(0, 1, 32'h2000_0000);
    clr_req(0);
    @(negedge clk);
    chk("contention_gap", 64'(grant), 64'(0));
    cyc();
    beats(1, 1, 32'h2100_0000);
    clr_req(1);

    // Master 0 alone, then both again: rotation favours master 1.
    cyc();
    set_req(0, 1'b0, 32'h0000_00C0, 4'd0, 32'h0, 4'h0);
    cyc();
    beats(0, 1, 32'h2200_0000);
    clr_req(0);
    cyc();
    set_req(0, 1'b0, 32'h0000_0100, 4'd0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0000_0140, 4'd0, 32'h0, 4'h0);
    cyc();
    first = RR ? 1 : 0;
    other = 1 - first;
    beats(first, 1, 32'h2300_0000);
    clr_req(first);
    cyc();
    beats(other, 1, 32'h2400_0000);
    clr_req(other);

    // Late request from master 1 during an 8-beat burst of master 0.
    cyc();
    set_req(0, 1'b0, 32'h0000_1000, 4'd7, 32'h0, 4'h0);
    cyc();
    for (int b = 0; b < 8; b++) begin
      if (b == 2) set_req(1, 1'b0, 32'h0000_2000, 4'd0, 32'h0, 4'h0);
      s_ready = 1'b1; s_last = (b == 7); s_rdata = 32'(b);
      @(negedge clk);
      chk("late_s_addr", 64'(s_addr), 64'h0000_1000);
      chk("late_grant", 64'(grant), 64'b01);
      cyc();
    end
    s_ready = 1'b0; s_last = 1'b0;
    clr_req(0);
    @(negedge clk);
    chk("late_idle", 64'(grant), 64'(0));
    cyc();
    beats(1, 1, 32'h2500_0000);
    clr_req(1);

    // Write fields forwarded unchanged.
    cyc();
    set_req(0, 1'b1, 32'h0000_0100, 4'd0, 32'hDEAD_BEEF, 4'b0011);
    cyc();
    @(negedge clk);
    chk("write_is_write", 64'(s_is_write), 64'(1));
    chk("write_strobe", 64'(s_strobe), 64'b0011);
    chk("write_data", 64'(s_data), 64'hDEAD_BEEF);
    cyc();
    beats(0, 1, 32'h0);
    clr_req(0);

    // Reset on beat 2 of a 4-beat burst, then a fresh request.
    cyc();
    set_req(0, 1'b0, 32'h0000_3000, 4'd3, 32'h0, 4'h0);
    cyc();
    s_ready = 1'b1; s_last = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; s_ready = 1'b0; clr_req(0);
    @(negedge clk);
    chk("rst_mid_s_valid", 64'(s_valid), 64'(0));
    chk("rst_mid_grant", 64'(grant), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    cyc();
    set_req(1, 1'b0, 32'h0000_4000, 4'd0, 32'h0, 4'h0);
    cyc();
    beats(1, 1, 32'h2600_0000);
    clr_req(1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset   = 1'b1;
        m_valid = '0;
      end
      for (int k = 0; k < int'(N); k++) begin
        if (m_valid[k] && done_q[k]) begin
          clr_req(k);
        end else if (!m_valid[k] && !reset && $urandom_range(0, 3) == 0) begin
          set_req(k, 1'($urandom), $urandom, 4'($urandom_range(0, 7)),
                  $urandom, 4'($urandom));
        end
      end
      if (mdl_busy) begin
        s_ready = ($urandom_range(0, 2) != 0);
        s_last  = s_ready && (beat_cnt == int'(m_len[4*mdl_owner +: 4]));
      end else begin
        s_ready = 1'($urandom);
        s_last  = 1'($urandom);
      end
      s_rdata = $urandom;
    end

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
